// File: rtl/dma_write_controller_if.sv
// dma_write_controller_if: TLP header/payload stream plus AXI4 read address/data channels.
interface dma_write_controller_if;
  logic [31:0]  tx_wr_addr;
  logic [9:0]   tx_wr_len;
  logic         tx_wr_valid;
  logic         tx_wr_ready;
  logic [127:0] tx_data;
  logic [3:0]   tx_data_dwen;
  logic         tx_data_valid;
  logic         tx_data_ready;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  modport master (
    output tx_wr_addr, tx_wr_len, tx_wr_valid, input tx_wr_ready,
    output tx_data, tx_data_dwen, tx_data_valid, input tx_data_ready,
    output araddr, arlen, arsize, arburst, arvalid, input arready,
    input rdata, rresp, rlast, rvalid, output rready
  );
  modport slave (
    input tx_wr_addr, tx_wr_len, tx_wr_valid, output tx_wr_ready,
    input tx_data, tx_data_dwen, tx_data_valid, output tx_data_ready,
    input araddr, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/dma_write_controller.sv
// dma_write_controller: device-to-host DMA; AXI reads streamed out as PCIe memory-write chunks.
module dma_write_controller #(
  parameter int P_MAX_PAYLOAD_BYTES = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] pcie_dcommand,
  input  logic [31:0] dma_write_host_address,
  input  logic [31:0] dma_write_device_address,
  input  logic [31:0] dma_write_length,
  input  logic        dma_write_start,
  output logic        busy,
  output logic        error,
  output logic        int_valid,
  input  logic        int_done,
  dma_write_controller_if.master bus
);
  localparam logic [31:0] MAX_B = 32'(P_MAX_PAYLOAD_BYTES);
  typedef enum logic [2:0] {IDLE, CALC, HDR, AR, DATA, INT} state_t;
  state_t state, state_n;
  logic [31:0] host, dev, rem, mps_raw, mps, m1, m2, chunk, host_room, dev_room, beats_m1, done_bytes, rem_n;
  logic [7:0] beat;
  logic fire, last, unused_ok;
  assign mps_raw = pcie_dcommand[7:5] == 3'd0 ? 32'd128 : pcie_dcommand[7:5] == 3'd1 ? 32'd256 : 32'd512;
  assign mps = mps_raw > MAX_B ? MAX_B : mps_raw;
  assign host_room = 32'd4096 - {20'd0, host[11:0]};
  assign dev_room = 32'd4096 - {20'd0, dev[11:0]};
  assign m1 = rem < mps ? rem : mps;
  assign m2 = m1 < host_room ? m1 : host_room;
  assign chunk = m2 < dev_room ? m2 : dev_room;
  assign beats_m1 = ((chunk + 32'd15) >> 4) - 32'd1;
  // Chunk size is recovered from the registered DW count when the chunk retires.
  assign done_bytes = {20'd0, bus.tx_wr_len, 2'b00};
  assign rem_n = rem - done_bytes;
  assign fire = state == DATA && bus.rvalid && bus.tx_data_ready;
  assign last = beat == bus.arlen;
  assign unused_ok = ^{pcie_dcommand[15:8], pcie_dcommand[4:0], chunk[31:12], chunk[1:0], beats_m1[31:8]};
  assign busy = state != IDLE;
  assign int_valid = state == INT;
  assign bus.tx_wr_valid = state == HDR;
  assign bus.arvalid = state == AR;
  assign bus.arsize = 3'b100;
  assign bus.arburst = 2'b01;
  assign bus.rready = state == DATA && bus.tx_data_ready;
  assign bus.tx_data_valid = state == DATA && bus.rvalid;
  assign bus.tx_data = bus.rdata;
  assign bus.tx_data_dwen = !last ? 4'b1111 :
                            bus.tx_wr_len[1:0] == 2'd1 ? 4'b0001 :
                            bus.tx_wr_len[1:0] == 2'd2 ? 4'b0011 :
                            bus.tx_wr_len[1:0] == 2'd3 ? 4'b0111 : 4'b1111;
  always_ff @(posedge i_clk)
    if (i_rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (dma_write_start) state_n = dma_write_length == 32'd0 ? INT : CALC;
      CALC: state_n = HDR;
      HDR:  if (bus.tx_wr_ready) state_n = AR;
      AR:   if (bus.arready) state_n = DATA;
      DATA: if (fire && last) state_n = rem_n == 32'd0 ? INT : CALC;
      INT:  if (int_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      host <= '0;
      dev <= '0;
      rem <= '0;
      error <= 1'b0;
      beat <= '0;
      bus.tx_wr_addr <= '0;
      bus.tx_wr_len <= '0;
      bus.araddr <= '0;
      bus.arlen <= '0;
    end else begin
      if (state == IDLE && dma_write_start) begin
        host <= dma_write_host_address;
        dev <= dma_write_device_address;
        rem <= dma_write_length;
        error <= 1'b0;
      end
      if (state == CALC) begin
        bus.tx_wr_len <= chunk[11:2];
        bus.arlen <= beats_m1[7:0];
        bus.araddr <= dev;
        bus.tx_wr_addr <= host;
        beat <= '0;
      end
      if (fire) begin
        beat <= beat + 8'd1;
        if (bus.rresp != 2'b00 || bus.rlast != last) error <= 1'b1;
        if (last) begin
          host <= host + done_bytes;
          dev <= dev + done_bytes;
          rem <= rem_n;
        end
      end
    end
  end
endmodule
